// File: rtl/cache_wbbuf_pkg.sv
// Shared defaults and state encoding for the D$ dirty-line writeback buffer.
package cache_wbbuf_pkg;

  localparam int unsigned WBBUF_ENTRIES = 4;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_BURST = 1'b1
  } wbstate_t;

endpackage

// File: rtl/cache_wbbuf_cam.sv
// Per-slot tag compare (one-hot match) plus and-or mux of the matching slot's line.
module cache_wbbuf_cam
  import cache_wbbuf_pkg::*;
#(
  parameter int unsigned NUMENTRIES = WBBUF_ENTRIES,
  parameter int unsigned TAGW       = 28,
  parameter int unsigned LINELEN    = 512
) (
  input  logic [NUMENTRIES-1:0] valid_i,
  input  logic [TAGW-1:0]       tag_i  [NUMENTRIES],
  input  logic [LINELEN-1:0]    line_i [NUMENTRIES],
  input  logic [TAGW-1:0]       lookup_tag_i,
  output logic [NUMENTRIES-1:0] match_o,
  output logic [LINELEN-1:0]    line_o
);

  // At most one slot matches, so OR-ing the gated rows is a clean select.
  always_comb begin
    match_o = '0;
    line_o  = '0;
    for (int i = 0; i < int'(NUMENTRIES); i++) begin
      match_o[i] = valid_i[i] && (tag_i[i] == lookup_tag_i);
      line_o     = line_o | ({LINELEN{match_o[i]}} & line_i[i]);
    end
  end

endmodule

// File: rtl/cache_wbbuf.sv
// Multi-entry dirty-line writeback buffer: one-cycle capture, oldest-first drain
// to the bus in AHBW beats, and reclaim of buffered lines on a later miss.
module cache_wbbuf
  import cache_wbbuf_pkg::*;
#(
  parameter int unsigned PA_BITS    = 34,
  parameter int unsigned LINELEN    = 512,
  parameter int unsigned AHBW       = 64,
  parameter int unsigned NUMENTRIES = WBBUF_ENTRIES,
  parameter int unsigned OFFSETLEN  = $clog2(LINELEN/8),
  parameter int unsigned LOGBWPL    = $clog2(LINELEN/AHBW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EnqValid,
  output logic               EnqReady,
  input  logic [PA_BITS-1:0] EnqAdr,
  input  logic [LINELEN-1:0] EnqLine,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupHit,
  output logic               LookupBusy,
  output logic [LINELEN-1:0] LookupLine,
  input  logic               Claim,
  output logic               BusWriteReq,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [AHBW-1:0]    BusBeatData,
  output logic [LOGBWPL-1:0] BeatCount,
  input  logic               BusBeatAck,
  output logic               Empty
);

  localparam int unsigned TAGW  = PA_BITS - OFFSETLEN;
  localparam int unsigned PTRW  = $clog2(NUMENTRIES);
  localparam int unsigned BEATS = LINELEN / AHBW;

  logic [NUMENTRIES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]       tag_q  [NUMENTRIES];
  logic [LINELEN-1:0]    line_q [NUMENTRIES];
  logic [PTRW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]       head_ptr_q, head_ptr_d;
  logic [LOGBWPL-1:0]    beat_q, beat_d;
  wbstate_t              state_q, state_d;

  logic [NUMENTRIES-1:0] match_c;
  logic [LINELEN-1:0]    head_line_c;
  logic                  burst_c;
  logic                  enq_fire_c;
  logic                  claim_fire_c;
  logic                  last_beat_c;
  logic                  dup_c;
  logic                  unused_c;

  cache_wbbuf_cam #(
    .NUMENTRIES (NUMENTRIES),
    .TAGW       (TAGW),
    .LINELEN    (LINELEN)
  ) u_cam (
    .valid_i      (valid_q),
    .tag_i        (tag_q),
    .line_i       (line_q),
    .lookup_tag_i (LookupAdr[PA_BITS-1:OFFSETLEN]),
    .match_o      (match_c),
    .line_o       (LookupLine)
  );

  assign unused_c = ^{EnqAdr[OFFSETLEN-1:0], LookupAdr[OFFSETLEN-1:0]};

  assign burst_c      = (state_q == WB_BURST);
  assign EnqReady     = ~valid_q[wr_ptr_q];
  assign enq_fire_c   = EnqValid && EnqReady;
  assign LookupBusy   = burst_c && match_c[head_ptr_q];
  assign LookupHit    = (|match_c) && !LookupBusy;
  assign claim_fire_c = Claim && LookupHit;
  assign last_beat_c  = (beat_q == LOGBWPL'(BEATS - 1));
  assign Empty        = ~|valid_q;

  assign BusWriteReq  = burst_c;
  assign BusAdr       = {tag_q[head_ptr_q], {OFFSETLEN{1'b0}}};
  assign BeatCount    = beat_q;
  assign head_line_c  = line_q[head_ptr_q];

  // Beat select from the head line.
  always_comb begin
    BusBeatData = '0;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (beat_q == LOGBWPL'(b)) BusBeatData = head_line_c[b*AHBW +: AHBW];
    end
  end

  // Next state: enqueue, claim and burst retirement touch disjoint slots.
  always_comb begin
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    head_ptr_d = head_ptr_q;
    beat_d     = beat_q;
    state_d    = state_q;

    if (enq_fire_c) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTRW'(1);
    end
    if (claim_fire_c) valid_d = valid_d & ~match_c;

    case (state_q)
      WB_IDLE: begin
        // A claim of the head wins over starting its burst.
        if (valid_q[head_ptr_q]) begin
          if (!(claim_fire_c && match_c[head_ptr_q])) state_d = WB_BURST;
        end else if (|valid_q) begin
          head_ptr_d = head_ptr_q + PTRW'(1);
        end
      end
      WB_BURST: begin
        if (BusBeatAck) begin
          beat_d = beat_q + LOGBWPL'(1);
          if (last_beat_c) begin
            valid_d[head_ptr_q] = 1'b0;
            head_ptr_d          = head_ptr_q + PTRW'(1);
            beat_d              = '0;
            state_d             = WB_IDLE;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      head_ptr_q <= '0;
      beat_q     <= '0;
      state_q    <= WB_IDLE;
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      head_ptr_q <= head_ptr_d;
      beat_q     <= beat_d;
      state_q    <= state_d;
    end
  end

  // Payload storage needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (enq_fire_c) begin
      tag_q[wr_ptr_q]  <= EnqAdr[PA_BITS-1:OFFSETLEN];
      line_q[wr_ptr_q] <= EnqLine;
    end
  end

  always_comb begin
    dup_c = 1'b0;
    for (int i = 0; i < int'(NUMENTRIES); i++) begin
      for (int j = i + 1; j < int'(NUMENTRIES); j++) begin
        if (valid_q[i] && valid_q[j] && (tag_q[i] == tag_q[j])) dup_c = 1'b1;
      end
    end
  end

  a_no_drop: assert property (@(posedge clk) disable iff (!reset) !(EnqValid && !EnqReady))
    else $error("cache_wbbuf: enqueue offered while full, line dropped");
  a_unique: assert property (@(posedge clk) disable iff (!reset) !dup_c)
    else $error("cache_wbbuf: two valid entries hold the same line");

endmodule
